// File: rtl/dmem_ctrl.sv
// Data-memory access controller: issues one bus transaction per load/store,
// stalls the pipeline until ack or timeout, and formats big-endian load data.
module dmem_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    input  logic [4:0]  waddr_i,
    input  logic        we_i,
    input  logic [31:0] wdata_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        stall_req_o,
    output logic [4:0]  waddr_o,
    output logic        we_o,
    output logic [31:0] wdata_o,
    output logic        exc_align_o,
    output logic        exc_timeout_o
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                           OP_LW = 4'd5, OP_SB  = 4'd6, OP_SH = 4'd7, OP_SW  = 4'd8;
    localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

    state_t      r_state, w_next;
    logic [3:0]  r_op;
    logic [1:0]  r_off;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_sel;
    logic [31:0] r_wdata;
    logic [7:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        r_timeout;

    logic        w_is_load, w_is_store, w_valid, w_misalign, w_start, w_r_is_load;
    logic [3:0]  w_sel;
    logic [31:0] w_bwdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ldata;

    // Request decode
    always_comb begin
        w_is_load  = (mem_op_i >= OP_LB) && (mem_op_i <= OP_LW);
        w_is_store = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);
        w_valid    = w_is_load || w_is_store;
        w_misalign = 1'b0;
        w_sel      = 4'b0000;
        w_bwdata   = '0;
        case (mem_op_i)
            OP_LB, OP_LBU, OP_SB: begin
                w_sel    = 4'b1000 >> addr_i[1:0];
                w_bwdata = {4{store_data_i[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                w_misalign = addr_i[0];
                w_sel      = addr_i[1] ? 4'b0011 : 4'b1100;
                w_bwdata   = {2{store_data_i[15:0]}};
            end
            OP_LW, OP_SW: begin
                w_misalign = (addr_i[1:0] != 2'b00);
                w_sel      = 4'b1111;
                w_bwdata   = store_data_i;
            end
            default: ;
        endcase
        w_start = (r_state == S_IDLE) && w_valid && !w_misalign;
    end

    // Load formatting uses the request latched at launch, not the live inputs
    always_comb begin
        w_r_is_load = (r_op >= OP_LB) && (r_op <= OP_LW);
        case (r_off)
            2'd0:    w_byte = bus_rdata_i[31:24];
            2'd1:    w_byte = bus_rdata_i[23:16];
            2'd2:    w_byte = bus_rdata_i[15:8];
            default: w_byte = bus_rdata_i[7:0];
        endcase
        w_half = r_off[1] ? bus_rdata_i[15:0] : bus_rdata_i[31:16];
        case (r_op)
            OP_LB:   w_ldata = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_ldata = {24'd0, w_byte};
            OP_LH:   w_ldata = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_ldata = {16'd0, w_half};
            default: w_ldata = bus_rdata_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_off     <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_sel     <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_op      <= mem_op_i;
                    r_off     <= addr_i[1:0];
                    r_we      <= w_is_store;
                    r_addr    <= {addr_i[31:2], 2'b00};
                    r_sel     <= w_sel;
                    r_wdata   <= w_bwdata;
                    r_cnt     <= '0;
                    r_rdata   <= '0;
                    r_timeout <= 1'b0;
                end
                S_ACCESS: begin
                    if (bus_ack_i) begin
                        r_rdata <= w_ldata;
                    end else if (r_cnt == LP_LAST) begin
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state and outputs; reset forces every output low combinationally
    always_comb begin
        w_next        = r_state;
        bus_req_o     = 1'b0;
        bus_we_o      = 1'b0;
        bus_addr_o    = '0;
        bus_sel_o     = '0;
        bus_wdata_o   = '0;
        stall_req_o   = 1'b0;
        waddr_o       = '0;
        we_o          = 1'b0;
        wdata_o       = '0;
        exc_align_o   = 1'b0;
        exc_timeout_o = 1'b0;
        case (r_state)
            S_IDLE: if (w_start) w_next = S_ACCESS;
            S_ACCESS: if (bus_ack_i || (r_cnt == LP_LAST)) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
        if (!rst) begin
            waddr_o = waddr_i;
            case (r_state)
                S_IDLE: begin
                    wdata_o = wdata_i;
                    if (!w_valid) begin
                        we_o = we_i;
                    end else if (w_misalign) begin
                        exc_align_o = 1'b1;
                    end else begin
                        stall_req_o = 1'b1;
                    end
                end
                S_ACCESS: begin
                    stall_req_o = 1'b1;
                    bus_req_o   = 1'b1;
                    bus_we_o    = r_we;
                    bus_addr_o  = r_addr;
                    bus_sel_o   = r_sel;
                    bus_wdata_o = r_wdata;
                end
                default: begin
                    if (r_timeout) begin
                        exc_timeout_o = 1'b1;
                    end else begin
                        we_o    = we_i;
                        wdata_o = w_r_is_load ? r_rdata : wdata_i;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: stimulus pushes expected write-backs,
// a negedge monitor pops them whenever the DUT presents one.
module tb_dmem_ctrl;

    localparam int unsigned TO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  mem_op_i;
    logic [31:0] addr_i, store_data_i, wdata_i, bus_rdata_i;
    logic [4:0]  waddr_i;
    logic        we_i, bus_ack_i;
    logic        bus_req_o, bus_we_o, stall_req_o, we_o, exc_align_o, exc_timeout_o;
    logic [31:0] bus_addr_o, bus_wdata_o, wdata_o;
    logic [3:0]  bus_sel_o;
    logic [4:0]  waddr_o;

    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        to;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    dmem_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .mem_op_i(mem_op_i), .addr_i(addr_i),
        .store_data_i(store_data_i), .waddr_i(waddr_i), .we_i(we_i), .wdata_i(wdata_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
        .bus_ack_i(bus_ack_i), .stall_req_o(stall_req_o), .waddr_o(waddr_o), .we_o(we_o),
        .wdata_o(wdata_o), .exc_align_o(exc_align_o), .exc_timeout_o(exc_timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Monitor: any write-back or timeout pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && (we_o || exc_timeout_o)) begin
            if (sb.size() == 0) begin
                chk("unexpected_wb", {31'd0, we_o}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_timeout", {31'd0, exc_timeout_o}, {31'd0, e.to});
                if (e.to) begin
                    chk("wb_we_on_timeout", {31'd0, we_o}, 32'd0);
                end else begin
                    chk("wb_waddr", {27'd0, waddr_o}, {27'd0, e.wa});
                    chk("wb_wdata", wdata_o, e.wd);
                end
            end
        end
    end

    task automatic idle_in();
        mem_op_i = 4'd0; addr_i = '0; store_data_i = '0;
        waddr_i = '0; we_i = 1'b0; wdata_i = '0; bus_ack_i = 1'b0; bus_rdata_i = '0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // ack_k = 0 means never acknowledge (timeout path)
    task automatic run_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                           input logic [4:0] wa, input logic wei, input logic [31:0] wdi,
                           input int ack_k, input logic [31:0] rdata,
                           input logic [3:0] esel, input logic [31:0] ebwd, input logic ebwe,
                           input logic [31:0] ewd);
        int done_c;
        exp_t e;
        done_c = (ack_k > 0) ? ack_k + 1 : int'(TO) + 1;
        step();
        mem_op_i = op; addr_i = addr; store_data_i = sd;
        waddr_i = wa; we_i = wei; wdata_i = wdi;
        e.wa = wa; e.wd = ewd; e.to = (ack_k == 0);
        if (wei || ack_k == 0) sb.push_back(e);
        @(negedge clk);
        chk("c0_stall", {31'd0, stall_req_o}, 32'd1);
        chk("c0_bus_req", {31'd0, bus_req_o}, 32'd0);
        chk("c0_we", {31'd0, we_o}, 32'd0);
        for (int c = 1; c <= done_c; c++) begin
            step();
            bus_ack_i = (c == ack_k);
            bus_rdata_i = (c == ack_k) ? rdata : 32'hDEAD_0000;
            @(negedge clk);
            if (c < done_c) begin
                chk("acc_stall", {31'd0, stall_req_o}, 32'd1);
                chk("acc_bus_req", {31'd0, bus_req_o}, 32'd1);
                chk("acc_we", {31'd0, we_o}, 32'd0);
                chk("acc_sel", {28'd0, bus_sel_o}, {28'd0, esel});
                chk("acc_addr", bus_addr_o, {addr[31:2], 2'b00});
                chk("acc_bus_we", {31'd0, bus_we_o}, {31'd0, ebwe});
                if (ebwe) chk("acc_bus_wdata", bus_wdata_o, ebwd);
            end else begin
                chk("done_stall", {31'd0, stall_req_o}, 32'd0);
                chk("done_bus_req", {31'd0, bus_req_o}, 32'd0);
            end
        end
        step();
        idle_in();
    endtask

    task automatic run_misalign(input logic [3:0] op, input logic [31:0] addr);
        step();
        mem_op_i = op; addr_i = addr; waddr_i = 5'd9; we_i = 1'b1; wdata_i = 32'h0BAD_0BAD;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mis_align", {31'd0, exc_align_o}, 32'd1);
            chk("mis_we", {31'd0, we_o}, 32'd0);
            chk("mis_stall", {31'd0, stall_req_o}, 32'd0);
            chk("mis_bus_req", {31'd0, bus_req_o}, 32'd0);
            step();
        end
        idle_in();
    endtask

    initial begin
        idle_in();
        rst = 1'b1;
        mem_op_i = 4'd0; waddr_i = 5'd4; we_i = 1'b1; wdata_i = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("rst_we", {31'd0, we_o}, 32'd0);
        chk("rst_waddr", {27'd0, waddr_o}, 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_stall", {31'd0, stall_req_o}, 32'd0);
        step();
        rst = 1'b0;
        idle_in();

        // Pass-through of a non-memory result
        step();
        mem_op_i = 4'd0; waddr_i = 5'd5; we_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
        sb.push_back('{wa: 5'd5, wd: 32'hDEAD_BEEF, to: 1'b0});
        @(negedge clk);
        chk("pt_stall", {31'd0, stall_req_o}, 32'd0);
        chk("pt_bus_req", {31'd0, bus_req_o}, 32'd0);
        step();
        idle_in();

        //        op    addr          store         wa  we  wdata      k  rdata         sel      bus_wdata     bwe  exp wb data
        run_mem(4'd5, 32'h100, 32'h0,          5'd3, 1, 32'h0,     3, 32'hCAFE_F00D, 4'b1111, 32'h0,         0, 32'hCAFE_F00D);
        run_mem(4'd1, 32'h103, 32'h0,          5'd4, 1, 32'h0,     1, 32'h0000_00F0, 4'b0001, 32'h0,         0, 32'hFFFF_FFF0);
        run_mem(4'd2, 32'h103, 32'h0,          5'd6, 1, 32'h0,     2, 32'h0000_00F0, 4'b0001, 32'h0,         0, 32'h0000_00F0);
        run_mem(4'd3, 32'h102, 32'h0,          5'd8, 1, 32'h0,     1, 32'h1234_8001, 4'b0011, 32'h0,         0, 32'hFFFF_8001);
        run_mem(4'd4, 32'h100, 32'h0,          5'd10,1, 32'h0,     1, 32'h8001_1234, 4'b1100, 32'h0,         0, 32'h0000_8001);
        run_mem(4'd1, 32'h100, 32'h0,          5'd11,1, 32'h0,     1, 32'h7F00_0000, 4'b1000, 32'h0,         0, 32'h0000_007F);
        run_mem(4'd7, 32'h202, 32'h1234_ABCD,  5'd7, 1, 32'h55,    2, 32'h0,         4'b0011, 32'hABCD_ABCD, 1, 32'h0000_0055);
        run_mem(4'd6, 32'h201, 32'h0000_00A5,  5'd0, 0, 32'h0,     1, 32'h0,         4'b0100, 32'hA5A5_A5A5, 1, 32'h0);
        run_mem(4'd8, 32'h204, 32'h1122_3344,  5'd0, 0, 32'h0,     1, 32'h0,         4'b1111, 32'h1122_3344, 1, 32'h0);

        run_misalign(4'd5, 32'h101);
        run_misalign(4'd3, 32'h103);

        // No ack: TIMEOUT access cycles then one timeout DONE cycle
        run_mem(4'd5, 32'h400, 32'h0,          5'd12,1, 32'h0,     0, 32'h0,         4'b1111, 32'h0,         0, 32'h0);

        // Reset raised in the second ACCESS cycle
        step();
        mem_op_i = 4'd5; addr_i = 32'h300; waddr_i = 5'd13; we_i = 1'b1;
        step();
        @(negedge clk);
        chk("rm_acc1_bus_req", {31'd0, bus_req_o}, 32'd1);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rm_bus_req", {31'd0, bus_req_o}, 32'd0);
        chk("rm_stall", {31'd0, stall_req_o}, 32'd0);
        chk("rm_we", {31'd0, we_o}, 32'd0);
        chk("rm_waddr", {27'd0, waddr_o}, 32'd0);
        chk("rm_sel", {28'd0, bus_sel_o}, 32'd0);
        step();
        rst = 1'b0;
        idle_in();
        @(negedge clk);
        chk("rm_after_bus_req", {31'd0, bus_req_o}, 32'd0);
        chk("rm_after_stall", {31'd0, stall_req_o}, 32'd0);
        run_mem(4'd5, 32'h300, 32'h0,          5'd14,1, 32'h0,     2, 32'h0102_0304, 4'b1111, 32'h0,         0, 32'h0102_0304);

        step();
        step();
        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
